id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, with integrated hazard detection.
//  Captures decode control signals, operands, register numbers and immediates for EX.
//  Detects load-use and branch-operand hazards: holds PC and IF/ID, inserts a bubble into EX.
// PARAMETERS
//  DW    32  datapath width (operands, immediate, pc_plus4)
//  RW    5   register-number width
//  AOPW  3   ALUop width; 3'b111 = nop
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  id_regWrite, id_memToReg, id_memRead, id_memWrite, id_ALUsrc, id_regDest  in 1 each  decode controls
//  id_ALUop       in   AOPW  decode ALU operation
//  id_branch      in   1     ID holds beq/bne (operands compared in ID)
//  id_uses_rt     in   1     ID instruction reads rt (R-type, sw, beq, bne)
//  id_valid       in   1     ID slot holds a real instruction
//  id_pc_plus4, id_rs_data, id_rt_data, id_imm  in DW  PC+4, operands, sign-extended imm
//  id_rs, id_rt, id_rd  in RW  register numbers
//  flush          in   1     squash ID instruction this cycle
//  mem_memRead    in   1     MEM stage holds a load
//  mem_dst        in   RW    MEM stage destination register
//  ex_* (one per id_* above except id_branch, id_uses_rt)  out  registered copies
//  ex_dst         out  RW    ex_regDest ? ex_rd : ex_rt
//  pc_write       out  1     0 = hold PC
//  ifid_write     out  1     0 = hold IF/ID
//  stall          out  1     combinational hazard indication
//  stall_count    out  32    stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): all ex_* control = 0, ex_ALUop = 3'b111, ex_valid = 0, data/reg-number regs = 0.
//  Latency: 1 cycle ID->EX. pc_write, ifid_write and stall are combinational from the current inputs and EX state.
//  Hazard (stall=1) when id_valid and flush=0 and any of:
//   a) load-use: ex_memRead & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt))
//   b) branch-ALU: id_branch & ex_regWrite & ex_dst!=0 & ex_dst matches rs or rt
//   c) branch-load: id_branch & mem_memRead & mem_dst!=0 & mem_dst matches rs or rt
//  stall=1: pc_write=0, ifid_write=0; next cycle EX gets a bubble.
//  Bubble: regWrite, memToReg, memRead, memWrite, ALUsrc, regDest and valid = 0; ALUop = 3'b111.
//  Data and register-number regs capture inputs every cycle, including on a bubble; their values are don't-care when ex_valid=0.
//  flush=1: bubble into EX; stall forced 0; pc_write=ifid_write=1 (flush wins over stall).
//  id_valid=0: bubble; stall=0.
//  Register $0 never causes a hazard.
//  A load followed by a dependent branch stalls 2 cycles: (a or b), then (c).
//  Reset asserted mid-stall: state clears immediately; after deassertion stall is re-evaluated from the inputs.
// CONFIGURATION
//  ID_EX_STALL_CNT_EN defined:
//   - stall_count increments on each clk edge where stall=1.
//   - It saturates at 32'hFFFF_FFFF and resets to 0.
//  ID_EX_STALL_CNT_EN undefined: stall_count tied to 32'd0; no counter flops.
// STRUCTURE
//  mips_pkg holds:
//   - ALUop encodings (ADD 000, SUB 001, AND 010, OR 011, SLT 100, NOP 111) and the opcode/funct constants.
//   - typedef struct ctrl_t: the decode control bundle.
//   - constant CTRL_BUBBLE.
//  Sub-module hazard_detect: purely combinational; computes stall from the ID register numbers, EX/MEM destinations and flags.
//  The pipeline registers and the optional counter stay in id_ex_stage.
// TESTING
//  1. Reset: drive all id_* = 1, pulse rst_n=0 -> all ex_* control 0, ex_ALUop=111, stall=0, stall_count=0.
//  2. lw $8 in EX (ex_memRead=1, ex_dst=8), then ID add rs=8 -> stall=1, pc_write=0 for 1 cycle, EX bubble, add enters EX next cycle.
//  3. add $9 in EX, then ID beq rs=9 -> 1 stall cycle.
//     lw $9 followed by beq rs=9 -> 2 stall cycles; stall_count +2 with ID_EX_STALL_CNT_EN.
//  4. lw $0 in EX, then ID add rs=0 -> stall=0.
//     Same hazard with flush=1 -> stall=0, EX bubble, pc_write=1.
//  5. Hazard held while rst_n pulses low mid-stall -> EX cleared at once, stall re-evaluates after release.
//     Stall for 2^32 cycles (forced counter) -> stall_count holds at FFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS core definitions: ALUop encodings, opcode/funct constants and the
// decode control bundle carried through ID/EX.
package mips_pkg;

    localparam int AOPW = 3;

    localparam logic [AOPW-1:0] ALU_ADD = 3'b000;
    localparam logic [AOPW-1:0] ALU_SUB = 3'b001;
    localparam logic [AOPW-1:0] ALU_AND = 3'b010;
    localparam logic [AOPW-1:0] ALU_OR  = 3'b011;
    localparam logic [AOPW-1:0] ALU_SLT = 3'b100;
    localparam logic [AOPW-1:0] ALU_NOP = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // ALUop travels alongside so its width can follow the stage parameter.
    typedef struct packed {
        logic regWrite;
        logic memToReg;
        logic memRead;
        logic memWrite;
        logic ALUsrc;
        logic regDest;
        logic valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, hazard inputs, and EX-side outputs.
interface id_ex_if #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int AOPW = 3
);
    logic            id_regWrite, id_memToReg, id_memRead, id_memWrite, id_ALUsrc, id_regDest;
    logic [AOPW-1:0] id_ALUop;
    logic            id_branch, id_uses_rt, id_valid;
    logic [DW-1:0]   id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0]   id_rs, id_rt, id_rd;
    logic            flush;
    logic            mem_memRead;
    logic [RW-1:0]   mem_dst;

    logic            ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_regDest;
    logic [AOPW-1:0] ex_ALUop;
    logic            ex_valid;
    logic [DW-1:0]   ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [RW-1:0]   ex_rs, ex_rt, ex_rd, ex_dst;
    logic            pc_write, ifid_write, stall;
    logic [31:0]     stall_count;

    modport master (
        output id_regWrite, id_memToReg, id_memRead, id_memWrite, id_ALUsrc, id_regDest,
               id_ALUop, id_branch, id_uses_rt, id_valid,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               flush, mem_memRead, mem_dst,
        input  ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_regDest,
               ex_ALUop, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_dst, pc_write, ifid_write, stall, stall_count
    );

    modport slave (
        input  id_regWrite, id_memToReg, id_memRead, id_memWrite, id_ALUsrc, id_regDest,
               id_ALUop, id_branch, id_uses_rt, id_valid,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               flush, mem_memRead, mem_dst,
        output ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_ALUsrc, ex_regDest,
               ex_ALUop, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_dst, pc_write, ifid_write, stall, stall_count
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational hazard detection: load-use, branch after ALU op, branch after load in MEM.
module hazard_detect #(
    parameter int RW = 5
) (
    input  logic          id_valid,
    input  logic          flush,
    input  logic          id_branch,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          ex_memRead,
    input  logic          ex_regWrite,
    input  logic [RW-1:0] ex_dst,
    input  logic          mem_memRead,
    input  logic [RW-1:0] mem_dst,
    output logic          stall
);
    logic ex_live, mem_live, load_use, br_alu, br_load;

    // $0 is hardwired zero, so it can never carry a real dependency.
    assign ex_live  = (ex_dst  != '0);
    assign mem_live = (mem_dst != '0);

    assign load_use = ex_memRead & ex_live &
                      ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
    assign br_alu   = id_branch & ex_regWrite & ex_live &
                      ((ex_dst == id_rs) | (ex_dst == id_rt));
    assign br_load  = id_branch & mem_memRead & mem_live &
                      ((mem_dst == id_rs) | (mem_dst == id_rt));

    assign stall = id_valid & ~flush & (load_use | br_alu | br_load);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and PC/IF-ID hold.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int AOPW = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    id_ex_if.slave bus
);
    ctrl_t           id_ctrl, ctrl_q;
    logic [AOPW-1:0] aluop_q;
    logic [DW-1:0]   pc_q, rsd_q, rtd_q, imm_q;
    logic [RW-1:0]   rs_q, rt_q, rd_q, dst;
    logic            stall, bubble;

    assign id_ctrl = '{regWrite: bus.id_regWrite, memToReg: bus.id_memToReg,
                       memRead:  bus.id_memRead,  memWrite: bus.id_memWrite,
                       ALUsrc:   bus.id_ALUsrc,   regDest:  bus.id_regDest,
                       valid:    bus.id_valid};

    assign dst = ctrl_q.regDest ? rd_q : rt_q;

    hazard_detect #(.RW(RW)) u_hazard (
        .id_valid    (bus.id_valid),
        .flush       (bus.flush),
        .id_branch   (bus.id_branch),
        .id_uses_rt  (bus.id_uses_rt),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_memRead  (ctrl_q.memRead),
        .ex_regWrite (ctrl_q.regWrite),
        .ex_dst      (dst),
        .mem_memRead (bus.mem_memRead),
        .mem_dst     (bus.mem_dst),
        .stall       (stall)
    );

    assign bubble = stall | bus.flush | ~bus.id_valid;

    // Only control is squashed; data fields are don't-care behind valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            aluop_q <= '1;
            pc_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= bubble ? CTRL_BUBBLE : id_ctrl;
            aluop_q <= bubble ? '1 : bus.id_ALUop;
            pc_q    <= bus.id_pc_plus4;
            rsd_q   <= bus.id_rs_data;
            rtd_q   <= bus.id_rt_data;
            imm_q   <= bus.id_imm;
            rs_q    <= bus.id_rs;
            rt_q    <= bus.id_rt;
            rd_q    <= bus.id_rd;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = 32'd0;
`endif

    assign bus.ex_regWrite = ctrl_q.regWrite;
    assign bus.ex_memToReg = ctrl_q.memToReg;
    assign bus.ex_memRead  = ctrl_q.memRead;
    assign bus.ex_memWrite = ctrl_q.memWrite;
    assign bus.ex_ALUsrc   = ctrl_q.ALUsrc;
    assign bus.ex_regDest  = ctrl_q.regDest;
    assign bus.ex_valid    = ctrl_q.valid;
    assign bus.ex_ALUop    = aluop_q;
    assign bus.ex_pc_plus4 = pc_q;
    assign bus.ex_rs_data  = rsd_q;
    assign bus.ex_rt_data  = rtd_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_dst      = dst;

    assign bus.stall      = stall;
    assign bus.pc_write   = ~stall;
    assign bus.ifid_write = ~stall;

endmodule
